// File: rtl/four_serial_sub_if.sv
// Handshake and data bundle for the bit-serial subtractor.
//
// Signals:
//   start      - request to begin a subtraction (requester -> subtractor)
//   A, B, bin  - minuend, subtrahend and borrow-in, captured with start
//   busy       - subtraction in progress (subtractor -> requester)
//   done       - one-cycle pulse when D/bout/v carry a new result
//   D          - difference A - B - bin, modulo 2^WIDTH
//   bout       - borrow-out, set when A < B + bin (unsigned)
//   v          - two's-complement overflow of the subtraction
//
// The master modport is the requester side; the slave modport is the subtractor.
interface four_serial_sub_if #(
    parameter int WIDTH = 4
) ();
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             bout;
    logic             v;

    modport master (
        output start, A, B, bin,
        input  busy, done, D, bout, v
    );

    modport slave (
        input  start, A, B, bin,
        output busy, done, D, bout, v
    );
endinterface

// File: rtl/four_serial_sub.sv
// Bit-serial subtractor: computes A - B - bin one bit per clock, LSB first.
// Operands are captured when start is seen in IDLE; WIDTH cycles later the
// difference, borrow-out and overflow flag are published together with a
// one-cycle done pulse. Results hold between completions.
//
// Ports:
//   clk  - clock, all state changes on its rising edge
//   rst  - synchronous active-high reset
//   bus  - four_serial_sub_if slave modport (start/A/B/bin in,
//          busy/done/D/bout/v out)
module four_serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    four_serial_sub_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             bout_q, bout_d;
    logic             v_q, v_d;
    logic             done_q, done_d;
    logic             diff_bit;
    logic             borrow_next;

    // Full-subtractor cell applied to the current LSBs of the shift registers.
    always_comb begin
        diff_bit    = a_q[0] ^ b_q[0] ^ br_q;
        borrow_next = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);
    end

    // Next-state and datapath logic. The operand MSBs are kept separately
    // because the shift registers have lost them by the time overflow is
    // evaluated. Result bits enter at the top so that after WIDTH shifts the
    // first (LSB) bit has reached bit 0.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        bout_d  = bout_q;
        v_d     = v_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    br_d    = bus.bin;
                    a_msb_d = bus.A[WIDTH-1];
                    b_msb_d = bus.B[WIDTH-1];
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = borrow_next;
                res_d = {diff_bit, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                // Last bit: publish the result on the same edge that
                // returns to IDLE, so busy and done never overlap.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    d_d     = res_d;
                    bout_d  = borrow_next;
                    v_d     = (a_msb_q != b_msb_q) & (diff_bit != a_msb_q);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset wins over both start and completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            bout_q  <= 1'b0;
            v_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            bout_q  <= bout_d;
            v_q     <= v_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
    assign bus.D    = d_q;
    assign bus.bout = bout_q;
    assign bus.v    = v_q;

endmodule

// File: tb/tb_four_serial_sub.sv
// Self-checking bench for four_serial_sub at WIDTH=4. Expected results are
// queued when an operation is launched and compared by a monitor whenever
// done pulses.
module tb_four_serial_sub;

    localparam int WIDTH = 4;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             bout;
        logic             v;
    } exp_t;

    logic clk;
    logic rst;
    int   errorCount;
    int   checkCount;
    exp_t expQ[$];
    exp_t lastExp;

    four_serial_sub_if #(.WIDTH(WIDTH)) bus ();

    four_serial_sub #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference model: widen by one bit so the borrow appears as bit WIDTH.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic bi);
        exp_t        r;
        logic [WIDTH:0] full;
        full   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bi};
        r.d    = full[WIDTH-1:0];
        r.bout = full[WIDTH];
        r.v    = (a[WIDTH-1] != b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        return r;
    endfunction

    // Scoreboard monitor: on every done pulse, pop the oldest expectation and
    // compare; a done with nothing queued is a spurious pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done) begin
                checkOutput("done_busy_excl", bus.busy, 0);
                if (expQ.size() == 0) begin
                    checkOutput("spurious_done", bus.done, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sb_D", bus.D, e.d);
                    checkOutput("sb_bout", bus.bout, e.bout);
                    checkOutput("sb_v", bus.v, e.v);
                    lastExp = e;
                end
            end
        end
    end

    // Launches one operation from a negedge and follows it to the done cycle.
    // Operands are scrambled during RUN to show they are not resampled; with
    // intrude set, a second start with different operands is pulsed during
    // the second RUN cycle and must be ignored. Returns at the done negedge so
    // a following call starts in the done cycle (back-to-back).
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic bi, input exp_t e, input bit intrude);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.bin   = bi;
        expQ.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = WIDTH'($urandom);
        bus.B     = WIDTH'($urandom);
        bus.bin   = 1'($urandom);
        checkOutput("busy_after_start", bus.busy, 1);
        checkOutput("done_low_after_start", bus.done, 0);
        for (int c = 1; c < WIDTH; c++) begin
            if (intrude && c == 2) begin
                bus.start = 1'b1;
                bus.A     = ~a;
                bus.B     = a;
                bus.bin   = ~bi;
            end
            @(negedge clk);
            bus.start = 1'b0;
            checkOutput("run_busy", bus.busy, 1);
            checkOutput("run_done", bus.done, 0);
            checkOutput("hold_D", bus.D, lastExp.d);
            checkOutput("hold_bout", bus.bout, lastExp.bout);
            checkOutput("hold_v", bus.v, lastExp.v);
        end
        @(negedge clk);
        checkOutput("latency_done", bus.done, 1);
        checkOutput("busy_at_done", bus.busy, 0);
    endtask

    // Main sequence: reset, the directed vectors, an ignored mid-run start,
    // random operands, then an aborted run followed by a fresh operation.
    initial begin
        exp_t e;
        logic [WIDTH-1:0] ra, rb;
        logic rbi;
        errorCount = 0;
        checkCount = 0;
        lastExp    = '0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        bus.bin    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_done", bus.done, 0);
        checkOutput("reset_D", bus.D, 0);
        checkOutput("reset_bout", bus.bout, 0);
        checkOutput("reset_v", bus.v, 0);
        rst = 1'b0;
        @(negedge clk);

        e = '{d: 4'h4, bout: 1'b0, v: 1'b0};
        applyStimulus(4'd7, 4'd3, 1'b0, e, 1'b0);
        e = '{d: 4'hE, bout: 1'b1, v: 1'b0};
        applyStimulus(4'd3, 4'd5, 1'b0, e, 1'b0);
        e = '{d: 4'h8, bout: 1'b1, v: 1'b1};
        applyStimulus(4'd7, 4'hF, 1'b0, e, 1'b0);
        e = '{d: 4'hF, bout: 1'b1, v: 1'b0};
        applyStimulus(4'd0, 4'd0, 1'b1, e, 1'b0);
        e = '{d: 4'h7, bout: 1'b0, v: 1'b1};
        applyStimulus(4'h8, 4'd1, 1'b0, e, 1'b0);

        // 5 - 6 - 1 = -2; the mid-run start must not launch a second op.
        e = '{d: 4'hE, bout: 1'b1, v: 1'b0};
        applyStimulus(4'd5, 4'd6, 1'b1, e, 1'b1);
        @(negedge clk);
        checkOutput("intrude_ignored", bus.busy, 0);

        for (int i = 0; i < 6; i++) begin
            ra  = WIDTH'($urandom_range(0, 15));
            rb  = WIDTH'($urandom_range(0, 15));
            rbi = 1'($urandom_range(0, 1));
            applyStimulus(ra, rb, rbi, model(ra, rb, rbi), 1'b0);
        end

        // Abort in the second RUN cycle; nothing is queued for this one.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 4'hA;
        bus.B     = 4'h3;
        bus.bin   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", bus.busy, 0);
        checkOutput("abort_done", bus.done, 0);
        checkOutput("abort_D", bus.D, 0);
        checkOutput("abort_bout", bus.bout, 0);
        checkOutput("abort_v", bus.v, 0);
        lastExp = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("abort_no_done", bus.done, 0);
        end

        e = '{d: 4'h7, bout: 1'b0, v: 1'b1};
        applyStimulus(4'd9, 4'd2, 1'b0, e, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("sb_drained", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
